// File: rtl/pwm_carrier_gen16_pkg.sv
// Shared constants for the PWM carrier generator.
// Mode and direction encodings used by the top and the bench.
package pwm_carrier_gen16_pkg;

  localparam int PWMWIDTH_DEF = 16;

  localparam logic MODE_SAW = 1'b0;
  localparam logic MODE_TRI = 1'b1;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/pwm_shadow_reg.sv
// Load-enabled shadow register with asynchronous active-high reset.
// Holds an active value that only changes at a carrier load point.
module pwm_shadow_reg #(
  parameter int PWMWIDTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [PWMWIDTH-1:0] d,
  output logic [PWMWIDTH-1:0] q
);

  logic [PWMWIDTH-1:0] val_q;
  logic [PWMWIDTH-1:0] val_d;

  always_comb begin
    val_d = val_q;
    if (load) val_d = d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) val_q <= '0;
    else     val_q <= val_d;
  end

  assign q = val_q;

endmodule

// File: rtl/pwm_carrier_gen16.sv
// Sawtooth / triangle PWM carrier with shadowed period, mode and
// compare registers that update only when the carrier reloads at 0.
module pwm_carrier_gen16
  import pwm_carrier_gen16_pkg::*;
#(
  parameter int PWMWIDTH = PWMWIDTH_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ce,
  input  logic                en,
  input  logic                sync_in,
  input  logic                mode_in,
  input  logic [PWMWIDTH-1:0] period_in,
  input  logic [PWMWIDTH-1:0] compare_1_in,
  input  logic [PWMWIDTH-1:0] compare_2_in,
  output logic [PWMWIDTH-1:0] carrier,
  output logic [PWMWIDTH-1:0] compare_1,
  output logic [PWMWIDTH-1:0] compare_2,
  output logic                dir,
  output logic                zero_evt,
  output logic                peak_evt
);

  localparam logic [PWMWIDTH-1:0] ONE = PWMWIDTH'(1);

  logic [PWMWIDTH-1:0] carrier_q, carrier_d;
  logic                dir_q, dir_d;
  logic                mode_q, mode_d;
  logic                zero_evt_q, zero_evt_d;
  logic                peak_evt_q, peak_evt_d;
  logic [PWMWIDTH-1:0] period_a;
  logic                load;

  always_comb begin
    carrier_d  = carrier_q;
    dir_d      = dir_q;
    load       = 1'b0;
    peak_evt_d = 1'b0;
    if (ce && sync_in) begin
      carrier_d = '0;
      dir_d     = DIR_UP;
      load      = 1'b1;
    end else if (ce && en) begin
      if (period_a == '0) begin
        carrier_d = '0;
      end else if (mode_q == MODE_SAW) begin
        dir_d     = DIR_UP;
        carrier_d = (carrier_q >= period_a) ? '0 : carrier_q + ONE;
      end else if (dir_q == DIR_DOWN) begin
        carrier_d = (carrier_q <= ONE) ? '0 : carrier_q - ONE;
      end else if (carrier_q >= period_a) begin
        carrier_d = carrier_q - ONE;
        dir_d     = DIR_DOWN;
      end else begin
        carrier_d = carrier_q + ONE;
      end
      load = (carrier_d == '0);
      // Any arrival at 0 starts a fresh upward cycle (covers period 1).
      if (load) dir_d = DIR_UP;
      peak_evt_d = (carrier_d == period_a) && (period_a != '0);
    end
    zero_evt_d = load;
    mode_d     = load ? mode_in : mode_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carrier_q  <= '0;
      dir_q      <= DIR_UP;
      mode_q     <= MODE_SAW;
      zero_evt_q <= 1'b0;
      peak_evt_q <= 1'b0;
    end else begin
      carrier_q  <= carrier_d;
      dir_q      <= dir_d;
      mode_q     <= mode_d;
      zero_evt_q <= zero_evt_d;
      peak_evt_q <= peak_evt_d;
    end
  end

  pwm_shadow_reg #(.PWMWIDTH(PWMWIDTH)) u_period (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .d    (period_in),
    .q    (period_a)
  );

  pwm_shadow_reg #(.PWMWIDTH(PWMWIDTH)) u_cmp1 (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .d    (compare_1_in),
    .q    (compare_1)
  );

  pwm_shadow_reg #(.PWMWIDTH(PWMWIDTH)) u_cmp2 (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .d    (compare_2_in),
    .q    (compare_2)
  );

  assign carrier  = carrier_q;
  assign dir      = dir_q;
  assign zero_evt = zero_evt_q;
  assign peak_evt = peak_evt_q;

endmodule

// File: tb/tb_pwm_carrier_gen16.sv
// Random-stimulus bench for pwm_carrier_gen16 against a phase-index
// model: carrier is derived from position k within the current cycle.
module tb_pwm_carrier_gen16;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         ce, en, sync_in, mode_in;
  logic [W-1:0] period_in, compare_1_in, compare_2_in;
  logic [W-1:0] carrier, compare_1, compare_2;
  logic         dir, zero_evt, peak_evt;

  int errors = 0;
  int checks = 0;

  // model state
  int m_k, m_p, m_c1, m_c2;
  bit m_mode, m_zev, m_pev;

  pwm_carrier_gen16 #(.PWMWIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .ce           (ce),
    .en           (en),
    .sync_in      (sync_in),
    .mode_in      (mode_in),
    .period_in    (period_in),
    .compare_1_in (compare_1_in),
    .compare_2_in (compare_2_in),
    .carrier      (carrier),
    .compare_1    (compare_1),
    .compare_2    (compare_2),
    .dir          (dir),
    .zero_evt     (zero_evt),
    .peak_evt     (peak_evt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int cyc_len();
    if (m_p == 0) return 1;
    return m_mode ? 2 * m_p : m_p + 1;
  endfunction

  function automatic int exp_carrier();
    if (!m_mode || m_k <= m_p) return m_k;
    return 2 * m_p - m_k;
  endfunction

  task automatic model_reset();
    m_k = 0; m_p = 0; m_c1 = 0; m_c2 = 0;
    m_mode = 0; m_zev = 0; m_pev = 0;
  endtask

  task automatic model_step();
    bit ld;
    ld = 0;
    m_zev = 0;
    m_pev = 0;
    if (ce && sync_in) begin
      m_k = 0;
      ld = 1;
    end else if (ce && en) begin
      m_k = m_k + 1;
      if (m_k >= cyc_len()) begin
        m_k = 0;
        ld = 1;
      end
      m_pev = (m_p != 0) && (m_k == m_p);
    end
    if (ld) begin
      m_zev = 1;
      m_p = int'(period_in);
      m_mode = mode_in;
      m_c1 = int'(compare_1_in);
      m_c2 = int'(compare_2_in);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".carrier"}, int'(carrier), exp_carrier());
    chk({tag, ".dir"}, int'(dir), int'(m_mode && m_k > m_p));
    chk({tag, ".cmp1"}, int'(compare_1), m_c1);
    chk({tag, ".cmp2"}, int'(compare_2), m_c2);
    chk({tag, ".zev"}, int'(zero_evt), int'(m_zev));
    chk({tag, ".pev"}, int'(peak_evt), int'(m_pev));
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    if (!rst) model_step();
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    check_all("rst_async");
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    ce = 0; en = 0; sync_in = 0; mode_in = 0;
    period_in = '0; compare_1_in = '0; compare_2_in = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    rst = 1'b0;

    // sawtooth period 4, continuous
    ce = 1; en = 1; period_in = 4; compare_1_in = 3; compare_2_in = 1;
    repeat (14) cycle("saw4");

    // triangle period 3 (takes effect at next load)
    mode_in = 1; period_in = 3;
    repeat (16) cycle("tri3");

    // 1-of-3 ce with an en=0 window
    for (int i = 0; i < 30; i++) begin
      ce = (i % 3 == 0);
      en = !(i >= 10 && i < 15);
      period_in = 5;
      cycle("ce3");
    end

    // sync mid-ramp, then async reset mid-ramp
    ce = 1; en = 1;
    repeat (7) cycle("pre_sync");
    sync_in = 1;
    compare_1_in = 16'hABCD;
    cycle("sync");
    sync_in = 0;
    repeat (5) cycle("post_sync");
    do_reset();

    // randomized run
    for (int i = 0; i < 3000; i++) begin
      ce = ($urandom_range(0, 9) < 8);
      en = ($urandom_range(0, 9) < 9);
      sync_in = ($urandom_range(0, 39) == 0);
      mode_in = $urandom_range(0, 1);
      if ($urandom_range(0, 7) == 0) period_in = W'($urandom_range(0, 9));
      if ($urandom_range(0, 199) == 0) period_in = 16'hFFFF;
      compare_1_in = W'($urandom);
      compare_2_in = W'($urandom);
      if ($urandom_range(0, 299) == 0) do_reset();
      else cycle("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pwm_carrier_gen16.md
PWM_CARRIER_GEN16 -- requirements
Module: pwm_carrier_gen16

Interface
REQ-001 SHALL have parameter PWMWIDTH, default 16, carrier/period/compare width in bits.
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on posedge clk.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port ce  input  1  count-enable tick; the counter advances only on a clk edge with ce=1.
REQ-005 SHALL have port en  input  1  run enable; en=0 freezes the counter, direction and shadows.
REQ-006 SHALL have port sync_in  input  1  restart request; forces a load point.
REQ-007 SHALL have port mode_in  input  1  carrier shape request: 0 = sawtooth up, 1 = triangle up/down.
REQ-008 SHALL have port period_in  input  PWMWIDTH  requested carrier peak value.
REQ-009 SHALL have ports compare_1_in, compare_2_in  input  PWMWIDTH  requested channel compare values.
REQ-010 SHALL have port carrier  output  PWMWIDTH  registered carrier count, feeding the compare stage.
REQ-011 SHALL have ports compare_1, compare_2  output  PWMWIDTH  active (shadow-loaded) compare values.
REQ-012 SHALL have port dir  output  1  registered count direction: 0 = up, 1 = down.
REQ-013 SHALL have ports zero_evt, peak_evt  output  1  one-clk pulses marking carrier==0 load and carrier==peak.

Function
REQ-014 SHALL hold active registers period_a, mode_a, compare_1, compare_2, updated only at a load point.
REQ-015 A load point SHALL be any ce=1 edge where the next carrier value is 0 and en=1, or any ce=1 edge with sync_in=1 (sync_in overrides en).
REQ-016 At a load point, period_a, mode_a, compare_1 and compare_2 SHALL capture period_in, mode_in, compare_1_in and compare_2_in.
REQ-017 Sawtooth (mode_a=0): if carrier >= period_a, next = 0 (load point); else next = carrier+1; dir SHALL stay 0.
REQ-018 Triangle up (mode_a=1, dir=0): if carrier >= period_a and period_a != 0, next = carrier-1 and dir -> 1; else next = carrier+1.
REQ-019 Triangle down (dir=1): if carrier <= 1, next = 0, dir -> 0 (load point); else next = carrier-1.
REQ-020 period_a = 0 in either mode SHALL hold carrier at 0, with every enabled ce edge a load point.
REQ-021 Sawtooth period SHALL be period_a+1 ticks; triangle period SHALL be 2*period_a ticks; 0 appears once per cycle.
REQ-022 sync_in at a ce=1 edge SHALL set carrier=0, dir=0 and perform a load, regardless of state; simultaneous natural wrap SHALL be identical.
REQ-023 zero_evt SHALL be 1 for exactly the clk cycle following a load-point edge; otherwise 0.
REQ-024 peak_evt SHALL be 1 for exactly the clk cycle following an edge that set carrier = period_a with period_a != 0 (triangle: at the turn).
REQ-025 A period_in change below the current carrier SHALL have no effect until the next load point (no runaway count).
REQ-026 ce=0 or en=0 (without sync_in) SHALL keep carrier, dir and actives unchanged; event outputs SHALL be 0.
REQ-027 All arithmetic SHALL be unsigned PWMWIDTH-bit; no wrap through 2^PWMWIDTH-1 shall occur, since period_a bounds the count.
REQ-028 Output latency: carrier, compare_x and events SHALL be valid 1 clk after the ce edge that produced them, all from the same edge.

Reset
REQ-029 rst=1 SHALL immediately clear carrier, dir, period_a, mode_a, compare_1, compare_2, zero_evt and peak_evt to 0.
REQ-030 After rst release, the first enabled ce edge SHALL be a load point (period_a=0 rule) capturing all inputs.
REQ-031 rst asserted mid-count SHALL discard the cycle; no partial shadow update SHALL survive.

Structure
REQ-032 Shared package SHALL hold PWMWIDTH default, MODE_SAW=0, MODE_TRI=1, DIR_UP=0 and DIR_DOWN=1 constants.
REQ-033 One sub-module, pwm_shadow_reg (PWMWIDTH-wide, load-enabled, async-reset register), SHALL be instanced for period, compare_1 and compare_2.

Verification
REQ-034 Reset, then period_in=4, mode_in=0, ce=en=1 continuous -> carrier 0,0,1,2,3,4,0,1...; zero_evt at each 0 after the first load; peak_evt at each 4.
REQ-035 period_in=3, mode_in=1 -> carrier 0,1,2,3,2,1,0,1...; dir 1 at values 2,1 after the peak; peak_evt at 3; zero_evt every 6 ticks.
REQ-036 Sawtooth period 10, carrier=7, change period_in to 5 and compare_1_in to 2 -> counts 8,9,10,0; then wraps at 5; compare_1 changes exactly at the 0.
REQ-037 ce toggling 1-of-3 clocks with en=0 for 5 cycles mid-count -> carrier frozen during en=0; it advances only on ce=1 edges; no events pulse.
REQ-038 Triangle, carrier=5 down, sync_in=1 -> next carrier 0, dir 0, zero_evt=1, shadows loaded; assert rst mid-ramp -> all outputs 0 asynchronously.
